// File: rtl/sub_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_DIGIT = 4;

endpackage

// File: rtl/subtract_digit.sv
// Combinational DIGIT-bit borrow chain built from full-subtractor cells.
module subtract_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    // Borrow out when a < b + borrow_in at this bit position.
    assign d[i]       = a[i] ^ b[i] ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor D = A - B - bin with start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, d_q;
  logic             brw_q, bout_q, ovf_q;
  logic             asign_q, bsign_q;

  logic [DIGIT-1:0] dig;
  logic             brw_n;
  logic [WIDTH-1:0] res_shift;
  logic             accept, last;

  subtract_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (brw_q),
    .d    (dig),
    .bout (brw_n)
  );

  // New digit enters at the top; after N shifts the LSB digit sits at the bottom.
  assign res_shift = WIDTH'({dig, res_q} >> DIGIT);

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      asign_q <= 1'b0;
      bsign_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        brw_q   <= bin;
        cnt_q   <= '0;
        asign_q <= A[WIDTH-1];
        bsign_q <= B[WIDTH-1];
      end else if (state_q == RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        res_q <= res_shift;
        brw_q <= brw_n;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          d_q    <= res_shift;
          bout_q <= brw_n;
          ovf_q  <= (asign_q != bsign_q) && (res_shift[WIDTH-1] != asign_q);
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 16;
  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] D;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .D       (D),
    .bout    (bout),
    .ovf     (ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {bout, D} = {0, A} - B - bin; ovf when operand signs differ and D's sign differs from A's.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    v    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return {v, full};
  endfunction

  // Issue one op, scramble inputs during RUN, and check busy length, done pulse and results.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W+1:0] exp;
    int           busy_cnt;
    bit           seen;
    exp = ref_sub(a, b, bi);
    @(negedge Clk);
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    busy_cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_cnt++;
        A = W'($urandom); B = W'($urandom); bin = 1'($urandom);
        @(negedge Clk);
      end
    end
    check_val({tag, ".done_seen"}, 32'(seen), 32'd1);
    check_val({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(N));
    check_val({tag, ".D"}, 32'(D), 32'(exp[W-1:0]));
    check_val({tag, ".bout"}, 32'(bout), 32'(exp[W]));
    check_val({tag, ".ovf"}, 32'(ovf), 32'(exp[W+1]));
    @(negedge Clk);
    check_val({tag, ".done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W+1:0] e;
    int           last_done;
    int           pulses;
    int           cyc;
    bit           any_done;

    // Reset state
    #12;
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    check_val("rst.D",    32'(D),    32'd0);
    check_val("rst.bout", 32'(bout), 32'd0);
    check_val("rst.ovf",  32'(ovf),  32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed cases
    run_op("dir55", 16'h0055, 16'h0045, 1'b0);
    run_op("dirBB", 16'h00BB, 16'h00F1, 1'b0);
    run_op("dir8000", 16'h8000, 16'h0001, 1'b0);
    run_op("dirzero", 16'h0000, 16'h0000, 1'b1);
    run_op("dirFFFF", 16'hFFFF, 16'h0000, 1'b0);
    run_op("dir7FFF", 16'h7FFF, 16'hFFFF, 1'b0);

    // start during RUN is ignored
    @(negedge Clk);
    A = 16'h1234; B = 16'h0034; bin = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    A = 16'hFFFF; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    any_done = 0;
    for (int i = 0; i < 10 && !any_done; i++) begin
      if (done) any_done = 1;
      else @(negedge Clk);
    end
    check_val("ign.done_seen", 32'(any_done), 32'd1);
    check_val("ign.D", 32'(D), 32'h1200);
    @(negedge Clk);
    check_val("ign.no_requeue", 32'(busy | done), 32'd0);

    // start held high: back-to-back ops, done every N+1 cycles
    A = 16'h0100; B = 16'h0001; bin = 1'b1; start = 1'b1;
    e = ref_sub(16'h0100, 16'h0001, 1'b1);
    last_done = -1;
    pulses = 0;
    for (cyc = 0; cyc < 40 && pulses < 3; cyc++) begin
      @(negedge Clk);
      if (done) begin
        check_val("b2b.D", 32'(D), 32'(e[W-1:0]));
        if (last_done >= 0) check_val("b2b.period", 32'(cyc - last_done), 32'(N + 1));
        last_done = cyc;
        pulses++;
      end
    end
    check_val("b2b.pulses", 32'(pulses), 32'd3);
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);

    // Reset mid-RUN aborts the op
    A = 16'h0F0F; B = 16'h0101; bin = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_val("abort.busy", 32'(busy), 32'd0);
    check_val("abort.D",    32'(D),    32'd0);
    check_val("abort.done", 32'(done), 32'd0);
    any_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (done) any_done = 1;
      if (i == 1) Reset_n = 1'b1;
    end
    check_val("abort.no_done", 32'(any_done), 32'd0);
    run_op("post_rst", 16'h0005, 16'h0003, 1'b0);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
